mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Byte-serial memory controller between the core and the 8-bit RAM/IO bus.
- Arbitrates three clients:
  - instruction fetch: word reads;
  - load buffer: 1/2/4-byte reads, consumes the load buffer's fetch request and returns data;
  - store path: 1/2/4-byte writes at commit.
- Runs one transaction at a time, assembling/splitting little-endian words and returning a one-cycle result pulse per request.

Parameters:
- ADDR_WIDTH, 32, address width of all client and bus addresses.
- IO_BASE, 32'h30000, addresses >= IO_BASE are IO space and subject to io_buffer_full stall.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; when low, all state and outputs freeze
- clear_in  in  1  mispredict flush
- if_enable_in  in  1  fetch request pulse
- if_addr_in  in  32  fetch address
- if_result_enable_out  out  1  fetch done pulse
- if_data_out  out  32  fetched word
- lb_enable_in  in  1  load request pulse
- lb_addr_in  in  32  load address
- lb_len_in  in  2  0=byte, 1=half, 3=word
- lb_result_enable_out  out  1  load done pulse
- lb_data_out  out  32  raw zero-extended load data; sign extension is done by the load buffer
- sb_enable_in  in  1  store request pulse
- sb_addr_in  in  32  store address
- sb_len_in  in  2  same encoding as lb_len_in
- sb_data_in  in  32  store data, low bytes used
- sb_done_out  out  1  store done pulse
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM address
- mem_wr  out  1  1=write, 0=read
- io_buffer_full  in  1  IO write back-pressure

Behaviour:
- Reset values:
  - all *_result_enable_out, sb_done_out, mem_wr: 0;
  - mem_a, mem_dout, data outputs: 0;
  - all pending flags cleared; state IDLE.
- Request capture:
  - any *_enable_in high at a clock edge (rdy=1) sets that client's pending flag and latches addr/len/data;
  - a client never issues a second request before its done pulse; behaviour in that case is undefined.
- Byte count N = len+1 (fetch: N=4). len=2 is never presented.
- Arbitration in IDLE, fixed priority: store > load > fetch. There is no preemption; a started transaction runs to completion (except reads under clear).
- States: IDLE, READ, WRITE.
- READ:
  - Issue cycle 0: mem_a = addr. Cycle i (i<N): mem_a = addr+i, mem_wr=0.
  - RAM latency is one cycle: byte i is valid on mem_din in cycle i+1 and is placed in bits [8i+7:8i].
  - Done pulse is high in cycle N+1, with data held stable until the next result. Return to IDLE in the same cycle.
  - Upper unused bytes are 0.
- WRITE:
  - Cycle i: mem_a = addr+i, mem_dout = data[8i+7:8i], mem_wr=1.
  - sb_done_out pulses in the cycle after the last byte.
- IO stall: in WRITE, if io_buffer_full=1 and addr >= IO_BASE, drive mem_wr=0 and hold the byte index that cycle; resume when io_buffer_full=0.
- Outside an active write byte, mem_wr=0.
- Done pulses are exactly one cycle wide.
- The next transaction may start the cycle after a done pulse.
- clear_in=1 at an edge:
  - drop the fetch and load pending flags;
  - abort an in-flight READ to IDLE, with no result pulse;
  - a pending or in-flight store is unaffected and completes normally.
- A new request arriving in the same cycle as clear_in is also dropped.
- Simultaneous requests: all are latched; they are served in priority order in successive transactions.
- Address wrap: addr+i wraps modulo 2^32.
- rdy=0: no state advances, mem_wr forced 0, pulses held.

Decomposition:
- Shared defines header: AddrType, WordType, length encodings (LenByte=0, LenHalf=1, LenWord=3), IO_BASE, True/False.
- One natural sub-module: mem_req_slot, the per-client pending flag plus latched addr/len/data. It is instantiated three times, with a clear input on the two read slots.

Test Plan:
- Load word at 0x100, RAM bytes 11,22,33,44 → lb_data_out=0x44332211, pulse in cycle 5 after issue, mem_a steps 0x100..0x103.
- Load byte at 0x203 holding 0x80 → lb_data_out=0x00000080, pulse in cycle 2.
- Fetch and load requested in the same cycle, with a store at 0x40 of 0xA1B2C3D4 one cycle earlier → order store, load, fetch; RAM[0x40..0x43]=D4,C3,B2,A1.
- clear_in asserted during cycle 2 of a load word → no lb_result_enable_out; a queued fetch is dropped; a queued store still writes.
- Store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for those 3 cycles, then one write, sb_done_out 1 cycle later.
- Halfword load at 0xFFFFFFFF → mem_a sequence 0xFFFFFFFF, 0x00000000; rdy dropped mid-load freezes mem_a and the data result.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;
  localparam int AddrWidth = 32;
  typedef logic [AddrWidth-1:0] AddrType;
  typedef logic [31:0]          WordType;
  typedef logic [1:0]           LenType;

  // Access length encodings: byte count is len+1 (2 is never used).
  localparam LenType LenByte = 2'd0;
  localparam LenType LenHalf = 2'd1;
  localparam LenType LenWord = 2'd3;

  localparam AddrType IoBaseDefault = 32'h0003_0000;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  // Controller states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  typedef enum logic [1:0] {CL_IF, CL_LB, CL_SB} client_e;

  function automatic logic [2:0] byte_count(LenType len);
    return {1'b0, len} + 3'd1;
  endfunction
endpackage

// File: rtl/mem_ctrl_req_slot.sv
// One client's request slot: pending flag plus latched addr/len/data.
module mem_req_slot
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clr,
  input  logic                  set,
  input  logic                  take,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  LenType                len_in,
  input  WordType               data_in,
  output logic                  pending,
  output logic [ADDR_WIDTH-1:0] addr,
  output LenType                len,
  output WordType               data
);

  // Flush wins over a same-cycle request; a grant consumes the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= False;
      addr    <= '0;
      len     <= LenByte;
      data    <= '0;
    end else if (rdy) begin
      if (clr) begin
        pending <= False;
      end else if (set) begin
        pending <= True;
        addr    <= addr_in;
        len     <= len_in;
        data    <= data_in;
      end else if (take) begin
        pending <= False;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch, load and store clients
// onto an 8-bit RAM/IO bus, one transaction at a time, little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(IoBaseDefault)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  clear_in,
  input  logic                  if_enable_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  output logic                  if_result_enable_out,
  output logic [31:0]           if_data_out,
  input  logic                  lb_enable_in,
  input  logic [ADDR_WIDTH-1:0] lb_addr_in,
  input  logic [1:0]            lb_len_in,
  output logic                  lb_result_enable_out,
  output logic [31:0]           lb_data_out,
  input  logic                  sb_enable_in,
  input  logic [ADDR_WIDTH-1:0] sb_addr_in,
  input  logic [1:0]            sb_len_in,
  input  logic [31:0]           sb_data_in,
  output logic                  sb_done_out,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  logic                  if_pend, lb_pend, sb_pend;
  logic [ADDR_WIDTH-1:0] if_addr, lb_addr, sb_addr;
  LenType                if_len, lb_len, sb_len;
  WordType               if_data, lb_data, sb_data;
  logic                  grant_if, grant_lb, grant_sb;

  logic [1:0]            state;
  client_e               cur_cl;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [2:0]            cur_n;
  WordType               cur_data;
  logic [2:0]            cnt;
  WordType               rd_buf, rd_next;
  logic [1:0]            rd_idx, wr_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  LenType                sel_len;
  WordType               sel_data;
  logic                  stall;

  mem_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_if_slot (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clear_in), .set(if_enable_in),
    .take(grant_if), .addr_in(if_addr_in), .len_in(LenWord), .data_in('0),
    .pending(if_pend), .addr(if_addr), .len(if_len), .data(if_data));

  mem_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_lb_slot (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clear_in), .set(lb_enable_in),
    .take(grant_lb), .addr_in(lb_addr_in), .len_in(lb_len_in), .data_in('0),
    .pending(lb_pend), .addr(lb_addr), .len(lb_len), .data(lb_data));

  // Stores survive a flush, so their slot never sees clear.
  mem_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb_slot (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(False), .set(sb_enable_in),
    .take(grant_sb), .addr_in(sb_addr_in), .len_in(sb_len_in), .data_in(sb_data_in),
    .pending(sb_pend), .addr(sb_addr), .len(sb_len), .data(sb_data));

  // Fixed-priority grant in IDLE (store > load > fetch); flushed reads never start.
  always_comb begin
    grant_sb = (state == ST_IDLE) && sb_pend;
    grant_lb = (state == ST_IDLE) && !sb_pend && lb_pend && !clear_in;
    grant_if = (state == ST_IDLE) && !sb_pend && !lb_pend && if_pend && !clear_in;
    sel_addr = if_addr;
    sel_len  = if_len;
    sel_data = if_data;
    if (sb_pend) begin
      sel_addr = sb_addr;
      sel_len  = sb_len;
      sel_data = sb_data;
    end else if (lb_pend) begin
      sel_addr = lb_addr;
      sel_len  = lb_len;
      sel_data = lb_data;
    end
  end

  // Read assembly: byte (cnt-1) arrives on mem_din while cnt counts issue cycles.
  always_comb begin
    rd_next = rd_buf;
    rd_idx  = cnt[1:0] - 2'd1;
    wr_idx  = cnt[1:0] + 2'd1;
    if (cnt != 3'd0) rd_next[{rd_idx, 3'b000} +: 8] = mem_din;
  end

  // IO writes hold in place while the IO buffer is full.
  assign stall  = io_buffer_full && (cur_addr >= IO_BASE);
  assign mem_wr = rdy && (state == ST_WRITE) && !stall;

  // Transaction sequencer; everything freezes while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= ST_IDLE;
      cur_cl               <= CL_IF;
      cur_addr             <= '0;
      cur_n                <= 3'd0;
      cur_data             <= '0;
      cnt                  <= 3'd0;
      rd_buf               <= '0;
      mem_a                <= '0;
      mem_dout             <= '0;
      if_result_enable_out <= False;
      lb_result_enable_out <= False;
      sb_done_out          <= False;
      if_data_out          <= '0;
      lb_data_out          <= '0;
    end else if (rdy) begin
      if_result_enable_out <= False;
      lb_result_enable_out <= False;
      sb_done_out          <= False;
      case (state)
        ST_IDLE: begin
          if (grant_sb || grant_lb || grant_if) begin
            state    <= grant_sb ? ST_WRITE : ST_READ;
            cur_cl   <= grant_sb ? CL_SB : (grant_lb ? CL_LB : CL_IF);
            cur_addr <= sel_addr;
            cur_n    <= byte_count(sel_len);
            cur_data <= sel_data;
            cnt      <= 3'd0;
            rd_buf   <= '0;
            mem_a    <= sel_addr;
            if (grant_sb) mem_dout <= sel_data[7:0];
          end
        end
        ST_READ: begin
          if (clear_in) begin
            state <= ST_IDLE;
          end else begin
            rd_buf <= rd_next;
            if (cnt == cur_n) begin
              state <= ST_IDLE;
              if (cur_cl == CL_IF) begin
                if_result_enable_out <= True;
                if_data_out          <= rd_next;
              end else begin
                lb_result_enable_out <= True;
                lb_data_out          <= rd_next;
              end
            end else begin
              cnt <= cnt + 3'd1;
              if (cnt + 3'd1 < cur_n) mem_a <= cur_addr + ADDR_WIDTH'(cnt + 3'd1);
            end
          end
        end
        ST_WRITE: begin
          if (!stall) begin
            if (cnt == cur_n - 3'd1) begin
              state       <= ST_IDLE;
              sb_done_out <= True;
            end else begin
              cnt      <= cnt + 3'd1;
              mem_a    <= cur_addr + ADDR_WIDTH'(cnt + 3'd1);
              mem_dout <= cur_data[{wr_idx, 3'b000} +: 8];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a one-cycle-latency byte RAM model.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy, clear_in;
  logic        if_enable_in, lb_enable_in, sb_enable_in;
  logic [31:0] if_addr_in, lb_addr_in, sb_addr_in, sb_data_in;
  logic [1:0]  lb_len_in, sb_len_in;
  logic        if_result_enable_out, lb_result_enable_out, sb_done_out;
  logic [31:0] if_data_out, lb_data_out;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  int checks = 0;
  int failures = 0;

  logic [7:0] ram [0:4095];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear_in(clear_in),
    .if_enable_in(if_enable_in), .if_addr_in(if_addr_in),
    .if_result_enable_out(if_result_enable_out), .if_data_out(if_data_out),
    .lb_enable_in(lb_enable_in), .lb_addr_in(lb_addr_in), .lb_len_in(lb_len_in),
    .lb_result_enable_out(lb_result_enable_out), .lb_data_out(lb_data_out),
    .sb_enable_in(sb_enable_in), .sb_addr_in(sb_addr_in), .sb_len_in(sb_len_in),
    .sb_data_in(sb_data_in), .sb_done_out(sb_done_out),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full));

  always #5 clk = ~clk;

  // RAM model: registered read, write on mem_wr, gated by the global enable.
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) ram[mem_a[11:0]] = mem_dout;
      mem_din <= ram[mem_a[11:0]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
    if_enable_in = 1'b0; lb_enable_in = 1'b0; sb_enable_in = 1'b0;
    if_addr_in = '0; lb_addr_in = '0; sb_addr_in = '0; sb_data_in = '0;
    lb_len_in = 2'd0; sb_len_in = 2'd0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    step(); step();
    checks++; if ({if_result_enable_out, lb_result_enable_out, sb_done_out} !== 3'b000) begin
      failures++; $display("FAIL reset_pulses got=%b exp=000", {if_result_enable_out, lb_result_enable_out, sb_done_out}); end
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
    checks++; if (mem_a !== 32'h0) begin failures++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
    checks++; if (mem_dout !== 8'h0) begin failures++; $display("FAIL reset_mem_dout got=%h exp=0", mem_dout); end
    checks++; if ({if_data_out, lb_data_out} !== 64'h0) begin
      failures++; $display("FAIL reset_data got=%h/%h exp=0/0", if_data_out, lb_data_out); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_load_word();
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
    lb_enable_in = 1'b1; lb_addr_in = 32'h100; lb_len_in = 2'd3;
    step();
    lb_enable_in = 1'b0;
    step();
    for (int c = 0; c <= 5; c++) begin
      if (c < 4) begin
        checks++; if (mem_a !== 32'h100 + c) begin
          failures++; $display("FAIL ldw_addr c=%0d got=%h exp=%h", c, mem_a, 32'h100 + c); end
        checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL ldw_mem_wr c=%0d got=%b exp=0", c, mem_wr); end
      end
      checks++; if (lb_result_enable_out !== (c == 5)) begin
        failures++; $display("FAIL ldw_pulse c=%0d got=%b exp=%b", c, lb_result_enable_out, (c == 5)); end
      if (c < 5) step();
    end
    checks++; if (lb_data_out !== 32'h44332211) begin
      failures++; $display("FAIL ldw_data got=%h exp=44332211", lb_data_out); end
    step();
    checks++; if (lb_result_enable_out !== 1'b0) begin failures++; $display("FAIL ldw_pulse_width got=1 exp=0"); end
    checks++; if (lb_data_out !== 32'h44332211) begin failures++; $display("FAIL ldw_hold got=%h exp=44332211", lb_data_out); end
  endtask

  task automatic test_load_byte();
    ram[12'h203] = 8'h80;
    lb_enable_in = 1'b1; lb_addr_in = 32'h203; lb_len_in = 2'd0;
    step();
    lb_enable_in = 1'b0;
    step();
    checks++; if (mem_a !== 32'h203) begin failures++; $display("FAIL ldb_addr got=%h exp=203", mem_a); end
    step();
    checks++; if (lb_result_enable_out !== 1'b0) begin failures++; $display("FAIL ldb_early got=1 exp=0"); end
    step();
    checks++; if (lb_result_enable_out !== 1'b1) begin failures++; $display("FAIL ldb_pulse got=0 exp=1"); end
    checks++; if (lb_data_out !== 32'h00000080) begin failures++; $display("FAIL ldb_data got=%h exp=00000080", lb_data_out); end
    step();
  endtask

  task automatic test_priority();
    int order [3];
    int n = 0;
    sb_enable_in = 1'b1; sb_addr_in = 32'h40; sb_len_in = 2'd3; sb_data_in = 32'hA1B2C3D4;
    step();
    sb_enable_in = 1'b0;
    if_enable_in = 1'b1; if_addr_in = 32'h40;
    lb_enable_in = 1'b1; lb_addr_in = 32'h102; lb_len_in = 2'd1;
    step();
    if_enable_in = 1'b0; lb_enable_in = 1'b0;
    for (int k = 0; k < 60 && n < 3; k++) begin
      if (sb_done_out) begin order[n] = 2; n++; end
      if (lb_result_enable_out && n < 3) begin order[n] = 1; n++; end
      if (if_result_enable_out && n < 3) begin order[n] = 0; n++; end
      step();
    end
    checks++; if (n !== 3) begin failures++; $display("FAIL prio_count got=%0d exp=3", n); end
    checks++; if (n == 3 && (order[0] !== 2 || order[1] !== 1 || order[2] !== 0)) begin
      failures++; $display("FAIL prio_order got=%0d,%0d,%0d exp=2,1,0 (sb,lb,if)", order[0], order[1], order[2]); end
    checks++; if ({ram[12'h43], ram[12'h42], ram[12'h41], ram[12'h40]} !== 32'hA1B2C3D4) begin
      failures++; $display("FAIL prio_ram got=%h exp=a1b2c3d4", {ram[12'h43], ram[12'h42], ram[12'h41], ram[12'h40]}); end
    checks++; if (lb_data_out !== 32'h00004433) begin failures++; $display("FAIL prio_lb_data got=%h exp=00004433", lb_data_out); end
    checks++; if (if_data_out !== 32'hA1B2C3D4) begin failures++; $display("FAIL prio_if_data got=%h exp=a1b2c3d4", if_data_out); end
  endtask

  task automatic test_clear();
    int sb_seen = 0;
    int rd_seen = 0;
    lb_enable_in = 1'b1; lb_addr_in = 32'h100; lb_len_in = 2'd3;
    step();
    lb_enable_in = 1'b0;
    if_enable_in = 1'b1; if_addr_in = 32'h100;
    sb_enable_in = 1'b1; sb_addr_in = 32'h50; sb_len_in = 2'd0; sb_data_in = 32'h0000005A;
    step();
    if_enable_in = 1'b0; sb_enable_in = 1'b0;
    step();
    step();
    clear_in = 1'b1;
    if_enable_in = 1'b1; if_addr_in = 32'h200;
    step();
    clear_in = 1'b0; if_enable_in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (sb_done_out) sb_seen++;
      if (lb_result_enable_out || if_result_enable_out) rd_seen++;
      step();
    end
    checks++; if (rd_seen !== 0) begin failures++; $display("FAIL clr_no_read got=%0d exp=0", rd_seen); end
    checks++; if (sb_seen !== 1) begin failures++; $display("FAIL clr_store_done got=%0d exp=1", sb_seen); end
    checks++; if (ram[12'h050] !== 8'h5A) begin failures++; $display("FAIL clr_store_ram got=%h exp=5a", ram[12'h050]); end
    checks++; if (lb_data_out !== 32'h00004433) begin failures++; $display("FAIL clr_lb_hold got=%h exp=00004433", lb_data_out); end
  endtask

  task automatic test_io_stall();
    io_buffer_full = 1'b1;
    sb_enable_in = 1'b1; sb_addr_in = 32'h30000; sb_len_in = 2'd0; sb_data_in = 32'h00000041;
    step();
    sb_enable_in = 1'b0;
    step();
    for (int c = 0; c < 3; c++) begin
      checks++; if (mem_wr !== 1'b0 || sb_done_out !== 1'b0) begin
        failures++; $display("FAIL io_stall c=%0d got wr=%b done=%b exp=0/0", c, mem_wr, sb_done_out); end
      step();
    end
    io_buffer_full = 1'b0;
    #1;
    checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h41) begin
      failures++; $display("FAIL io_write got wr=%b a=%h d=%h exp=1/30000/41", mem_wr, mem_a, mem_dout); end
    step();
    checks++; if (sb_done_out !== 1'b1 || mem_wr !== 1'b0) begin
      failures++; $display("FAIL io_done got done=%b wr=%b exp=1/0", sb_done_out, mem_wr); end
    step();
    checks++; if (sb_done_out !== 1'b0) begin failures++; $display("FAIL io_done_width got=1 exp=0"); end
    checks++; if (ram[12'h000] !== 8'h41) begin failures++; $display("FAIL io_ram got=%h exp=41", ram[12'h000]); end
  endtask

  task automatic test_wrap_rdy();
    ram[12'hFFF] = 8'h9C; ram[12'h000] = 8'h7E;
    lb_enable_in = 1'b1; lb_addr_in = 32'hFFFFFFFF; lb_len_in = 2'd1;
    step();
    lb_enable_in = 1'b0;
    step();
    checks++; if (mem_a !== 32'hFFFFFFFF) begin failures++; $display("FAIL wrap_a0 got=%h exp=ffffffff", mem_a); end
    step();
    checks++; if (mem_a !== 32'h00000000) begin failures++; $display("FAIL wrap_a1 got=%h exp=00000000", mem_a); end
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (mem_a !== 32'h0 || lb_result_enable_out !== 1'b0 || lb_data_out !== 32'h00004433 || mem_wr !== 1'b0) begin
        failures++; $display("FAIL freeze c=%0d got a=%h p=%b d=%h wr=%b exp 0/0/4433/0", c, mem_a, lb_result_enable_out, lb_data_out, mem_wr); end
    end
    rdy = 1'b1;
    step();
    checks++; if (lb_result_enable_out !== 1'b0) begin failures++; $display("FAIL wrap_early got=1 exp=0"); end
    step();
    checks++; if (lb_result_enable_out !== 1'b1 || lb_data_out !== 32'h00007E9C) begin
      failures++; $display("FAIL wrap_result got p=%b d=%h exp=1/00007e9c", lb_result_enable_out, lb_data_out); end
    step();
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_byte();
    test_priority();
    test_clear();
    test_io_stall();
    test_wrap_rdy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
